sqrt_pipe_requester: RTL and testbench

- Initiator/client side of the fixed-latency, non-stallable clocked square-root pipeline (4-cycle latency, 1/cycle throughput, signed Q17.14 with 1.0 = 0x4000).
- Accepts tagged operands over a valid/ready handshake and drives them into the pipeline.
- Tracks in-flight operations with a tag/valid delay line and captures results into a result FIFO.
- Returns results in order over a valid/ready handshake, so ray-setup logic can tolerate backpressure from a pipeline that cannot stall.

---
 rtl/sqrt_pipe_requester_pkg.sv | 12 +
 rtl/sqrt_pipe_requester_fifo.sv | 46 ++++
 rtl/sqrt_pipe_requester.sv | 112 +++++++++++
 tb/tb_sqrt_pipe_requester.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sqrt_pipe_requester_pkg.sv
// Shared fixed-point maths definitions for the square-root pipeline and its clients.
package Maths;

  localparam int SQRT_PIPE_LATENCY = 4;
  localparam int FIXED_FRAC_BITS   = 14;
  localparam logic signed [31:0] FIXED_ONE = 32'sh4000;
  localparam int SQRT_TAG_WIDTH    = 4;

  typedef logic signed [31:0]           fixed_t;
  typedef logic [SQRT_TAG_WIDTH-1:0]    sqrt_tag_t;

endpackage

// File: rtl/sqrt_pipe_requester_fifo.sv
// Show-ahead result FIFO with asynchronous reset; head is zero while empty.
module sqrt_result_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices coincide.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  assign pop_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/sqrt_pipe_requester.sv
// Client of the fixed-latency sqrt pipeline: tags operations, absorbs backpressure.
// Optional negative-operand trapping via `define SQRT_PIPE_REQUESTER_NEG_CHECK_EN.
module sqrt_pipe_requester
  import Maths::*;
#(
  parameter int LATENCY    = SQRT_PIPE_LATENCY,
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  reqValid,
  output logic                  reqReady,
  input  logic [DATA_WIDTH-1:0] reqOperand,
  input  logic [TAG_WIDTH-1:0]  reqTag,
  output logic [DATA_WIDTH-1:0] pipeOperand,
  input  logic [DATA_WIDTH-1:0] pipeResult,
  output logic                  respValid,
  input  logic                  respReady,
  output logic [DATA_WIDTH-1:0] respResult,
  output logic [TAG_WIDTH-1:0]  respTag,
  output logic                  respError
);

  localparam int OCC_W = $clog2(FIFO_DEPTH + 1);

  logic [OCC_W-1:0]     occ;
  logic                 issue;
  logic                 pop;
  logic [LATENCY-1:0]   dl_valid;
  logic [TAG_WIDTH-1:0] dl_tag [LATENCY];
  logic                 fifo_full;
  logic                 fifo_empty;

  // Credits cover in-flight plus stored results, so a capture always has room.
  assign reqReady  = (occ < OCC_W'(FIFO_DEPTH));
  assign issue     = reqValid & reqReady;
  assign respValid = !fifo_empty;
  assign pop       = respValid & respReady;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      occ <= '0;
    end else if (issue && !pop) begin
      occ <= occ + 1'b1;
    end else if (!issue && pop) begin
      occ <= occ - 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dl_valid <= '0;
      for (int unsigned i = 0; i < LATENCY; i++) dl_tag[i] <= '0;
    end else begin
      dl_valid  <= {dl_valid[LATENCY-2:0], issue};
      dl_tag[0] <= reqTag;
      for (int unsigned i = 1; i < LATENCY; i++) dl_tag[i] <= dl_tag[i-1];
    end
  end

`ifdef SQRT_PIPE_REQUESTER_NEG_CHECK_EN
  localparam int ENTRY_W = DATA_WIDTH + TAG_WIDTH + 1;

  logic [LATENCY-1:0] dl_neg;
  logic               req_neg;
  logic [ENTRY_W-1:0] push_data;
  logic [ENTRY_W-1:0] pop_data;

  assign req_neg     = reqOperand[DATA_WIDTH-1];
  assign pipeOperand = (issue && !req_neg) ? reqOperand : '0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) dl_neg <= '0;
    else       dl_neg <= {dl_neg[LATENCY-2:0], req_neg};
  end

  assign push_data = {dl_neg[LATENCY-1],
                      dl_neg[LATENCY-1] ? {DATA_WIDTH{1'b0}} : pipeResult,
                      dl_tag[LATENCY-1]};
  assign {respError, respResult, respTag} = pop_data;
`else
  localparam int ENTRY_W = DATA_WIDTH + TAG_WIDTH;

  logic [ENTRY_W-1:0] push_data;
  logic [ENTRY_W-1:0] pop_data;

  assign pipeOperand = issue ? reqOperand : '0;
  assign push_data   = {pipeResult, dl_tag[LATENCY-1]};
  assign {respResult, respTag} = pop_data;
  assign respError   = 1'b0;
`endif

  sqrt_result_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (dl_valid[LATENCY-1]),
    .push_data (push_data),
    .pop       (pop),
    .pop_data  (pop_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  a_no_overflow: assert property (@(posedge clock) disable iff (reset)
    !(dl_valid[LATENCY-1] && fifo_full && !pop));

endmodule

// File: tb/tb_sqrt_pipe_requester.sv
// Self-checking bench for sqrt_pipe_requester with a behavioural sqrt pipeline.
module tb_sqrt_pipe_requester;

  localparam int LAT   = 4;
  localparam int DW    = 32;
  localparam int TW    = 4;
  localparam int DEPTH = 8;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          reqValid = 1'b0;
  logic          reqReady;
  logic [DW-1:0] reqOperand = '0;
  logic [TW-1:0] reqTag = '0;
  logic [DW-1:0] pipeOperand;
  logic [DW-1:0] pipeResult;
  logic          respValid;
  logic          respReady = 1'b0;
  logic [DW-1:0] respResult;
  logic [TW-1:0] respTag;
  logic          respError;

  int     n_checks = 0;
  int     n_err    = 0;
  longint cyc      = 0;

  logic [DW-1:0] sb_op [$];
  logic [TW-1:0] sb_tag [$];

  bit            pop_v;
  bit            pop_has;
  logic [DW-1:0] pop_res;
  logic [TW-1:0] pop_tag;
  logic          pop_err;
  logic [DW-1:0] pop_exp_op;
  logic [TW-1:0] pop_exp_tag;

  logic [DW-1:0] pipe_q [LAT];

  always #5 clock = ~clock;

  sqrt_pipe_requester #(
    .LATENCY    (LAT),
    .DATA_WIDTH (DW),
    .TAG_WIDTH  (TW),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .reqValid    (reqValid),
    .reqReady    (reqReady),
    .reqOperand  (reqOperand),
    .reqTag      (reqTag),
    .pipeOperand (pipeOperand),
    .pipeResult  (pipeResult),
    .respValid   (respValid),
    .respReady   (respReady),
    .respResult  (respResult),
    .respTag     (respTag),
    .respError   (respError)
  );

  // Environment: unreset, non-stallable pipeline, bit-exact integer sqrt in Q17.14.
  function automatic logic [31:0] pipe_sqrt(logic [31:0] op);
    longint unsigned v, r, t;
    if (op[31]) return '0;
    v = {32'd0, op} << 14;
    r = 0;
    for (int b = 23; b >= 0; b--) begin
      t = r | (64'd1 << b);
      if (t * t <= v) r = t;
    end
    return r[31:0];
  endfunction

  initial for (int i = 0; i < LAT; i++) pipe_q[i] = '0;

  always @(posedge clock) begin
    pipe_q[0] <= pipe_sqrt(pipeOperand);
    for (int i = 1; i < LAT; i++) pipe_q[i] <= pipe_q[i-1];
  end
  assign pipeResult = pipe_q[LAT-1];

  // Reference: real-valued sqrt of the fixed-point operand.
  function automatic int exp_result(logic [31:0] op);
    if (op[31]) return 0;
    return $rtoi($sqrt(real'(op) * 16384.0));
  endfunction

  function automatic logic exp_err(logic [31:0] op);
`ifdef SQRT_PIPE_REQUESTER_NEG_CHECK_EN
    return op[31];
`else
    return 1'b0;
`endif
  endfunction

  // Advance one clock, recording the issue and the popped response of this cycle.
  task automatic step();
    pop_v   = respValid && respReady;
    pop_res = respResult;
    pop_tag = respTag;
    pop_err = respError;
    pop_has = 1'b0;
    if (reqValid && reqReady) begin
      sb_op.push_back(reqOperand);
      sb_tag.push_back(reqTag);
    end
    if (pop_v && sb_op.size() > 0) begin
      pop_exp_op  = sb_op.pop_front();
      pop_exp_tag = sb_tag.pop_front();
      pop_has     = 1'b1;
    end
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    int n;
    int d;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    n_checks++;
    if (reqReady !== 1'b1 || respValid !== 1'b0 || respResult !== '0 || respTag !== '0 || respError !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state: reqReady=%b respValid=%b res=%h tag=%h err=%b, want 1 0 0 0 0",
               reqReady, respValid, respResult, respTag, respError);
    end
    reset = 1'b0;
    @(posedge clock); #1;
    reqOperand = 32'h0001_0000; reqTag = 4'd3; reqValid = 1'b1;
    step();
    reqValid = 1'b0;
    n = 1;
    while (!respValid && n < 20) begin step(); n++; end
    n_checks++;
    if (n != LAT + 1) begin
      n_err++;
      $display("FAIL first_latency: got %0d cycles, want %0d", n, LAT + 1);
    end
    d = int'(respResult) - 32'h8000;
    n_checks++;
    if (d > 2 || d < -2 || respTag !== 4'd3 || respError !== 1'b0) begin
      n_err++;
      $display("FAIL sqrt4: res=%h tag=%0d err=%b, want ~8000 tag=3 err=0", respResult, respTag, respError);
    end
    respReady = 1'b1; step(); respReady = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] ops  [4] = '{32'h4000, 32'h1_0000, 32'h2_4000, 32'h0};
    int            exps [4] = '{32'h4000, 32'h8000, 32'hC000, 0};
    int     k = 0;
    int     d;
    longint last = 0;
    respReady = 1'b1;
    for (int i = 0; i < 4; i++) begin
      reqOperand = ops[i]; reqTag = TW'(i); reqValid = 1'b1;
      step();
    end
    reqValid = 1'b0;
    for (int i = 0; i < 20 && k < 4; i++) begin
      step();
      if (pop_v) begin
        d = int'(pop_res) - exps[k];
        n_checks++;
        if (d > 2 || d < -2 || pop_tag !== TW'(k) || (k > 0 && cyc != last + 1)) begin
          n_err++;
          $display("FAIL b2b_%0d: res=%h tag=%0d gap=%0d, want ~%h tag=%0d gap=1",
                   k, pop_res, pop_tag, cyc - last, exps[k], k);
        end
        last = cyc;
        k++;
      end
    end
    n_checks++;
    if (k != 4) begin
      n_err++;
      $display("FAIL b2b_count: got %0d results, want 4", k);
    end
    respReady = 1'b0;
  endtask

  task automatic test_backpressure();
    int issued = 0;
    int pops = 0;
    int d;
    respReady = 1'b0;
    reqValid  = 1'b1;
    for (int i = 0; i < 20; i++) begin
      reqOperand = $urandom_range(0, 32'h0040_0000); reqTag = TW'(i);
      if (reqReady) issued++;
      step();
    end
    n_checks++;
    if (issued != DEPTH || reqReady !== 1'b0 || pipeOperand !== '0) begin
      n_err++;
      $display("FAIL bp_fill: issued=%0d reqReady=%b pipeOperand=%h, want %0d 0 0",
               issued, reqReady, pipeOperand, DEPTH);
    end
    respReady = 1'b1; step(); respReady = 1'b0;
    issued = 0;
    for (int i = 0; i < 10; i++) begin
      reqOperand = $urandom_range(0, 32'h0040_0000); reqTag = TW'(i);
      if (reqReady) issued++;
      step();
    end
    n_checks++;
    if (issued != 1) begin
      n_err++;
      $display("FAIL bp_one_more: issued=%0d, want 1", issued);
    end
    reqValid = 1'b0; respReady = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step();
      if (pop_v) begin
        pops++;
        d = pop_has ? int'(pop_res) - exp_result(pop_exp_op) : 0;
        n_checks++;
        if (!pop_has || d > 2 || d < -2 || pop_tag !== pop_exp_tag) begin
          n_err++;
          $display("FAIL bp_data: res=%h tag=%0d, want ~%h tag=%0d (expected=%b)",
                   pop_res, pop_tag, exp_result(pop_exp_op), pop_exp_tag, pop_has);
        end
      end
    end
    n_checks++;
    if (pops != DEPTH || sb_op.size() != 0) begin
      n_err++;
      $display("FAIL bp_drain: pops=%0d leftover=%0d, want %0d 0", pops, sb_op.size(), DEPTH);
    end
    respReady = 1'b0;
  endtask

  task automatic test_simul_issue_pop();
    int issued = 0;
    int pops = 0;
    respReady = 1'b0;
    reqValid  = 1'b1;
    for (int i = 0; i < 20 && issued < DEPTH - 1; i++) begin
      reqOperand = $urandom_range(0, 32'h0010_0000); reqTag = TW'(i);
      if (reqReady) issued++;
      step();
    end
    reqValid = 1'b0;
    repeat (LAT + 2) step();
    n_checks++;
    if (reqReady !== 1'b1 || respValid !== 1'b1) begin
      n_err++;
      $display("FAIL simul_pre: reqReady=%b respValid=%b, want 1 1", reqReady, respValid);
    end
    reqValid = 1'b1; respReady = 1'b1; reqTag = 4'hA;
    step();
    respReady = 1'b0;
    n_checks++;
    if (reqReady !== 1'b1) begin
      n_err++;
      $display("FAIL simul_hold: reqReady=%b, want 1", reqReady);
    end
    reqTag = 4'hB;
    step();
    reqValid = 1'b0;
    n_checks++;
    if (reqReady !== 1'b0) begin
      n_err++;
      $display("FAIL simul_full: reqReady=%b, want 0", reqReady);
    end
    respReady = 1'b1;
    for (int i = 0; i < 30; i++) begin
      step();
      if (pop_v) pops++;
    end
    n_checks++;
    if (pops != DEPTH || sb_op.size() != 0) begin
      n_err++;
      $display("FAIL simul_drain: pops=%0d leftover=%0d, want %0d 0", pops, sb_op.size(), DEPTH);
    end
    respReady = 1'b0;
  endtask

  task automatic test_neg();
    int n = 0;
    respReady = 1'b0;
    reqOperand = 32'hFFFF_C000; reqTag = 4'd7; reqValid = 1'b1;
    step();
    reqValid = 1'b0;
    while (!respValid && n < 20) begin step(); n++; end
    n_checks++;
    if (respValid !== 1'b1 || respTag !== 4'd7 || respError !== exp_err(32'hFFFF_C000) || respResult !== '0) begin
      n_err++;
      $display("FAIL neg_operand: valid=%b res=%h tag=%0d err=%b, want 1 0 7 %b",
               respValid, respResult, respTag, respError, exp_err(32'hFFFF_C000));
    end
    respReady = 1'b1; step(); respReady = 1'b0;
  endtask

  task automatic test_random();
    bit            held_v = 1'b0;
    logic [DW-1:0] held_res;
    logic [TW-1:0] held_tag;
    int            d;
    for (int i = 0; i < 400; i++) begin
      if (held_v) begin
        n_checks++;
        if (respValid !== 1'b1 || respResult !== held_res || respTag !== held_tag) begin
          n_err++;
          $display("FAIL rand_hold: valid=%b res=%h tag=%0d, want 1 %h %0d",
                   respValid, respResult, respTag, held_res, held_tag);
        end
      end
      reqValid   = ($urandom_range(0, 3) != 0);
      respReady  = ($urandom_range(0, 2) != 0);
      reqOperand = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 | $urandom : $urandom_range(0, 32'h7FFF_FFFF);
      reqTag     = TW'($urandom);
      held_v   = respValid && !respReady;
      held_res = respResult;
      held_tag = respTag;
      step();
      if (pop_v) begin
        d = pop_has ? int'(pop_res) - exp_result(pop_exp_op) : 0;
        n_checks++;
        if (!pop_has || d > 2 || d < -2 || pop_tag !== pop_exp_tag || pop_err !== exp_err(pop_exp_op)) begin
          n_err++;
          $display("FAIL rand_resp: res=%h tag=%0d err=%b, want ~%h tag=%0d err=%b (expected=%b)",
                   pop_res, pop_tag, pop_err, exp_result(pop_exp_op), pop_exp_tag, exp_err(pop_exp_op), pop_has);
        end
      end
    end
    reqValid = 1'b0; respReady = 1'b1;
    for (int i = 0; i < 30; i++) begin
      step();
      if (pop_v) begin
        d = pop_has ? int'(pop_res) - exp_result(pop_exp_op) : 0;
        n_checks++;
        if (!pop_has || d > 2 || d < -2 || pop_tag !== pop_exp_tag || pop_err !== exp_err(pop_exp_op)) begin
          n_err++;
          $display("FAIL rand_drain: res=%h tag=%0d err=%b, want ~%h tag=%0d err=%b",
                   pop_res, pop_tag, pop_err, exp_result(pop_exp_op), pop_exp_tag, exp_err(pop_exp_op));
        end
      end
    end
    n_checks++;
    if (sb_op.size() != 0) begin
      n_err++;
      $display("FAIL rand_lost: %0d results never returned, want 0", sb_op.size());
    end
    respReady = 1'b0;
  endtask

  task automatic test_reset_midflight();
    bit stale = 1'b0;
    respReady = 1'b0;
    reqValid  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      reqOperand = $urandom_range(0, 32'h0040_0000); reqTag = TW'(i);
      step();
    end
    reqValid = 1'b0;
    step();
    n_checks++;
    if (respValid !== 1'b1 || reqReady !== 1'b1) begin
      n_err++;
      $display("FAIL mid_pre: respValid=%b reqReady=%b, want 1 1", respValid, reqReady);
    end
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (respValid !== 1'b0 || reqReady !== 1'b1) begin
      n_err++;
      $display("FAIL mid_reset: respValid=%b reqReady=%b, want 0 1", respValid, reqReady);
    end
    @(posedge clock); #1;
    reset = 1'b0;
    sb_op.delete();
    sb_tag.delete();
    respReady = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (respValid !== 1'b0) stale = 1'b1;
      step();
    end
    n_checks++;
    if (stale) begin
      n_err++;
      $display("FAIL mid_stale: respValid seen=1 after reset, want 0");
    end
    respReady = 1'b0;
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_backpressure();
    test_simul_issue_pop();
    test_neg();
    test_random();
    test_reset_midflight();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
